// File: rtl/drv_deadtime_gate_pkg.sv
// Shared types and defaults for the dead-time gate stage: leg state encoding,
// default sizing constants and the effective dead-time clamp.
package drv_deadtime_gate_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    DEAD_H = 3'd1,
    HI     = 3'd2,
    DEAD_L = 3'd3,
    LO     = 3'd4
  } leg_state_t;

  localparam int DEF_DT_BITS    = 8;
  localparam int DEF_MIN_DT     = 2;
  localparam int DEF_OCD_FILTER = 4;

  function automatic int unsigned dt_clamp(input int unsigned dt, input int unsigned min_dt);
    return (dt < min_dt) ? min_dt : dt;
  endfunction

endpackage

// File: rtl/drv_deadtime_gate_dt_leg.sv
// One half-bridge leg: registers its command, walks OFF/DEAD/HI/LO and holds
// both gates low for exactly dt_eff cycles per transition; no backpressure.
module dt_leg
  import drv_deadtime_gate_pkg::*;
#(
  parameter int DT_BITS = DEF_DT_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               force_off,
  input  logic               cmd,
  input  logic [DT_BITS-1:0] dt_eff,
  output logic               hi,
  output logic               lo
);

  leg_state_t         state, state_nxt;
  logic [DT_BITS-1:0] cnt, cnt_nxt;
  logic               cmd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      cmd_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cmd_q <= cmd;
    end
  end

  // Every entry into a dead state reloads the counter, so a reversal can only lengthen the gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_off) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = cmd_q ? DEAD_H : DEAD_L;
          cnt_nxt   = dt_eff;
        end
        LO: begin
          if (cmd_q) begin
            state_nxt = DEAD_H;
            cnt_nxt   = dt_eff;
          end
        end
        HI: begin
          if (!cmd_q) begin
            state_nxt = DEAD_L;
            cnt_nxt   = dt_eff;
          end
        end
        DEAD_H: begin
          if (!cmd_q) begin
            state_nxt = DEAD_L;
            cnt_nxt   = dt_eff;
          end else if (cnt <= DT_BITS'(1)) begin
            state_nxt = HI;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - DT_BITS'(1);
          end
        end
        DEAD_L: begin
          if (cmd_q) begin
            state_nxt = DEAD_H;
            cnt_nxt   = dt_eff;
          end else if (cnt <= DT_BITS'(1)) begin
            state_nxt = LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - DT_BITS'(1);
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hi = (state == HI);
    lo = (state == LO);
  end

endmodule

// File: rtl/drv_deadtime_gate.sv
// Two-leg dead-time gate driver with optional latched overcurrent shutdown
// (DRV_DEADTIME_OCD_EN); gates follow commands after 1+dt_eff cycles, no backpressure.
module drv_deadtime_gate
  import drv_deadtime_gate_pkg::*;
#(
  parameter int DT_BITS    = DEF_DT_BITS,
  parameter int MIN_DT     = DEF_MIN_DT,
  parameter int OCD_FILTER = DEF_OCD_FILTER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               drv0_cmd,
  input  logic               drv1_cmd,
  input  logic [DT_BITS-1:0] deadtime,
  input  logic               ocd_in,
  input  logic               ocd_clr,
  output logic               drv0_hi,
  output logic               drv0_lo,
  output logic               drv1_hi,
  output logic               drv1_lo,
  output logic               fault
);

  logic [DT_BITS-1:0] dt_eff;
  logic               fault_nxt;
  logic               force_off;

  assign dt_eff = DT_BITS'(dt_clamp(32'(deadtime), 32'(MIN_DT)));

`ifdef DRV_DEADTIME_OCD_EN
  localparam int OCW = $clog2(OCD_FILTER + 1);

  logic           ocd_meta, ocd_sync;
  logic [OCW-1:0] ocd_cnt;
  logic           fault_q;
  logic           trip;

  always_ff @(posedge clk) begin
    if (rst) begin
      ocd_meta <= 1'b0;
      ocd_sync <= 1'b0;
      ocd_cnt  <= '0;
      fault_q  <= 1'b0;
    end else begin
      ocd_meta <= ocd_in;
      ocd_sync <= ocd_meta;
      if (!ocd_sync)
        ocd_cnt <= '0;
      else if (ocd_cnt != OCW'(OCD_FILTER))
        ocd_cnt <= ocd_cnt + OCW'(1);
      fault_q <= fault_nxt;
    end
  end

  // Trip on the cycle the run length reaches OCD_FILTER; a trip overrides a clear.
  assign trip = ocd_sync && (ocd_cnt >= OCW'(OCD_FILTER - 1));

  always_comb begin
    fault_nxt = fault_q;
    if (trip)
      fault_nxt = 1'b1;
    else if (ocd_clr && !ocd_sync)
      fault_nxt = 1'b0;
  end

  assign fault = fault_q;
`else
  logic unused_ocd;
  assign unused_ocd = ocd_in ^ ocd_clr ^ (OCD_FILTER > 0);
  assign fault_nxt  = 1'b0;
  assign fault      = 1'b0;
`endif

  // Next-state fault gates the legs so outputs drop on the same edge fault rises.
  assign force_off = ~en | fault_nxt;

  dt_leg #(.DT_BITS(DT_BITS)) u_leg0 (
    .clk       (clk),
    .rst       (rst),
    .force_off (force_off),
    .cmd       (drv0_cmd),
    .dt_eff    (dt_eff),
    .hi        (drv0_hi),
    .lo        (drv0_lo)
  );

  dt_leg #(.DT_BITS(DT_BITS)) u_leg1 (
    .clk       (clk),
    .rst       (rst),
    .force_off (force_off),
    .cmd       (drv1_cmd),
    .dt_eff    (dt_eff),
    .hi        (drv1_hi),
    .lo        (drv1_lo)
  );

endmodule
